// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner
// encoding and counter widths.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   localparam int STREAK_W = 4;
   localparam int TMO_W    = 10;

   function automatic logic word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational owner selection: data side wins unless the fetch side has
// already waited through MAX_DM_STREAK consecutive data grants.
module mem_arb_select
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_DM_STREAK = 4
) (
   input  logic                if_req,
   input  logic                dm_req,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant_valid,
   output owner_t              grant_owner
);

   logic if_starved;

   assign if_starved  = if_req && (streak == STREAK_W'(MAX_DM_STREAK));
   assign grant_valid = if_req | dm_req;
   assign grant_owner = (dm_req && !if_starved) ? OWN_DM : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data
// access, with request/ack sequencing, starvation guard, timeout and alignment check.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int MAX_DM_STREAK  = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_stall,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t              state_reg, state_next;
   owner_t              owner_reg;
   logic                err_reg;
   logic [STREAK_W-1:0] streak_reg;
   logic [TMO_W-1:0]    tmo_cnt_reg;
   logic                mem_req_reg, mem_we_reg;
   logic [ADDR_W-1:0]   mem_addr_reg;
   logic [DATA_W-1:0]   mem_wdata_reg, if_rdata_reg, dm_rdata_reg;

   logic                grant_valid;
   owner_t              grant_owner;
   logic [ADDR_W-1:0]   sel_addr;
   logic                sel_aligned;
   logic                timeout_hit;

   mem_arb_select #(
      .MAX_DM_STREAK(MAX_DM_STREAK)
   ) u_select (
      .if_req     (if_req),
      .dm_req     (dm_req),
      .streak     (streak_reg),
      .grant_valid(grant_valid),
      .grant_owner(grant_owner)
   );

   assign sel_addr    = (grant_owner == OWN_DM) ? dm_addr : if_addr;
   assign sel_aligned = word_aligned(sel_addr[1:0]);
   assign timeout_hit = (tmo_cnt_reg == TMO_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (grant_valid) begin
               state_next = sel_aligned ? ST_BUSY : ST_RESP;
            end
         end
         ST_BUSY: begin
            if (mem_ack || timeout_hit) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Misaligned accesses skip the memory entirely and report straight from RESP.
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_reg     <= OWN_IF;
         err_reg       <= 1'b0;
         streak_reg    <= '0;
         tmo_cnt_reg   <= '0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         if_rdata_reg  <= '0;
         dm_rdata_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (grant_valid) begin
                  owner_reg   <= grant_owner;
                  tmo_cnt_reg <= '0;
                  if (grant_owner == OWN_DM && if_req) begin
                     if (streak_reg != STREAK_MAX) begin
                        streak_reg <= streak_reg + STREAK_W'(1);
                     end
                  end else begin
                     streak_reg <= '0;
                  end
                  if (sel_aligned) begin
                     err_reg       <= 1'b0;
                     mem_req_reg   <= 1'b1;
                     mem_we_reg    <= (grant_owner == OWN_DM) && dm_we;
                     mem_addr_reg  <= sel_addr;
                     mem_wdata_reg <= (grant_owner == OWN_DM) ? dm_wdata : '0;
                  end else begin
                     err_reg <= 1'b1;
                     if (grant_owner == OWN_DM) begin
                        dm_rdata_reg <= '0;
                     end else begin
                        if_rdata_reg <= '0;
                     end
                  end
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
                  err_reg     <= 1'b0;
                  if (owner_reg == OWN_DM) begin
                     dm_rdata_reg <= mem_rdata;
                  end else begin
                     if_rdata_reg <= mem_rdata;
                  end
               end else if (timeout_hit) begin
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
                  err_reg     <= 1'b1;
                  if (owner_reg == OWN_DM) begin
                     dm_rdata_reg <= '0;
                  end else begin
                     if_rdata_reg <= '0;
                  end
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign if_done   = (state_reg == ST_RESP) && (owner_reg == OWN_IF);
   assign dm_done   = (state_reg == ST_RESP) && (owner_reg == OWN_DM);
   assign bus_err   = (state_reg == ST_RESP) && err_reg;
   assign if_stall  = if_req & ~if_done;
   assign dm_stall  = dm_req & ~dm_done;
   assign if_rdata  = if_rdata_reg;
   assign dm_rdata  = dm_rdata_reg;
   assign mem_req   = mem_req_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;

endmodule
